// File: rtl/pwm_fade_ctrl_if.sv
// Fade command channel between LED command logic and pwm_fade_ctrl.
// Latency: none, wires only.
// Backpressure: cmd_ready from the slave qualifies cmd_valid from the master.
interface pwm_fade_ctrl_if #(
  parameter int PWM_WIDTH  = 4,
  parameter int RATE_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_chan;
  logic [PWM_WIDTH-1:0]  cmd_target;
  logic [RATE_WIDTH-1:0] cmd_rate;
  logic                  cmd_loop;

  modport master (
    output cmd_valid, cmd_chan, cmd_target, cmd_rate, cmd_loop,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_chan, cmd_target, cmd_rate, cmd_loop,
    output cmd_ready
  );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Two-channel duty sequencer: ramps each channel's duty 1 LSB per cmd_rate ticks to target.
// Latency: command applied one clk after acceptance; done one clk after duty reaches target.
// Backpressure: none after reset; cmd_ready is registered and stays high. Breathe mode: FADE_BREATHE_EN.
module pwm_fade_ctrl #(
  parameter int PWM_WIDTH  = 4,
  parameter int RATE_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tick_en,
  pwm_fade_ctrl_if.slave       cmd,
  output logic [PWM_WIDTH-1:0] duty1,
  output logic [PWM_WIDTH-1:0] duty2,
  output logic [1:0]           busy,
  output logic [1:0]           done
);

  typedef enum logic {IDLE, RAMP} state_e;

  logic                  rdy_q;
  logic                  accept;
  logic                  pend_vld_q;
  logic                  pend_chan_q;
  logic [PWM_WIDTH-1:0]  pend_target_q;
  logic [RATE_WIDTH-1:0] pend_rate_q;
  logic [PWM_WIDTH-1:0]  duty_w [2];

`ifdef FADE_BREATHE_EN
  logic                  pend_loop_q;
`else
  logic                  unused_loop;
  assign unused_loop = cmd.cmd_loop;
`endif

  assign cmd.cmd_ready = rdy_q;
  assign accept        = cmd.cmd_valid & rdy_q;

  // Ready comes up on the first edge out of reset and never drops again.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  // Accepted command is staged one cycle before it reaches the channel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_vld_q    <= 1'b0;
      pend_chan_q   <= 1'b0;
      pend_target_q <= '0;
      pend_rate_q   <= '0;
`ifdef FADE_BREATHE_EN
      pend_loop_q   <= 1'b0;
`endif
    end else begin
      pend_vld_q <= accept;
      if (accept) begin
        pend_chan_q   <= cmd.cmd_chan;
        pend_target_q <= cmd.cmd_target;
        pend_rate_q   <= cmd.cmd_rate;
`ifdef FADE_BREATHE_EN
        pend_loop_q   <= cmd.cmd_loop;
`endif
      end
    end
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    localparam logic CH = (c == 1);

    state_e                state_q, state_d;
    logic [PWM_WIDTH-1:0]  duty_q,  duty_d;
    logic [PWM_WIDTH-1:0]  ep_q,    ep_d;     // current ramp endpoint
    logic [RATE_WIDTH-1:0] rate_q,  rate_d;
    logic [RATE_WIDTH-1:0] cnt_q,   cnt_d;
    logic                  done_q,  done_d;
    logic                  hit;               // staged command lands on this channel now
    logic                  acc;               // command for this channel accepted this edge
`ifdef FADE_BREATHE_EN
    logic                  loop_q,  loop_d;
    logic [PWM_WIDTH-1:0]  peak_q,  peak_d;   // latched target, the far end of a breathe
`endif

    assign hit = pend_vld_q && (pend_chan_q == CH);
    assign acc = accept && (cmd.cmd_chan == CH);

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= IDLE;
        duty_q  <= '0;
        ep_q    <= '0;
        rate_q  <= '0;
        cnt_q   <= '0;
        done_q  <= 1'b0;
`ifdef FADE_BREATHE_EN
        loop_q  <= 1'b0;
        peak_q  <= '0;
`endif
      end else begin
        state_q <= state_d;
        duty_q  <= duty_d;
        ep_q    <= ep_d;
        rate_q  <= rate_d;
        cnt_q   <= cnt_d;
        done_q  <= done_d;
`ifdef FADE_BREATHE_EN
        loop_q  <= loop_d;
        peak_q  <= peak_d;
`endif
      end
    end

    // Next state: a landing command overrides everything; an accepted command
    // freezes the channel for that edge so its tick is dropped and no stale done fires.
    always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      ep_d    = ep_q;
      rate_d  = rate_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
`ifdef FADE_BREATHE_EN
      loop_d  = loop_q;
      peak_d  = peak_q;
`endif
      if (hit) begin
        ep_d   = pend_target_q;
        rate_d = pend_rate_q;
        cnt_d  = '0;
`ifdef FADE_BREATHE_EN
        loop_d = pend_loop_q;
        peak_d = pend_target_q;
`endif
        if (pend_target_q == duty_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (pend_rate_q == '0) begin
          duty_d  = pend_target_q;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = RAMP;
        end
      end else if (state_q == RAMP && !acc) begin
        if (duty_q == ep_q) begin
          done_d  = 1'b1;
`ifdef FADE_BREATHE_EN
          if (loop_q && peak_q != '0) ep_d = (ep_q == '0) ? peak_q : '0;
          else                        state_d = IDLE;
`else
          state_d = IDLE;
`endif
        end else if (tick_en) begin
          if (cnt_q == rate_q - 1'b1) begin
            cnt_d  = '0;
            duty_d = (duty_q < ep_q) ? duty_q + 1'b1 : duty_q - 1'b1;
          end else begin
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
    end

    assign busy[c]   = (state_q == RAMP);
    assign done[c]   = done_q;
    assign duty_w[c] = duty_q;
  end

  assign duty1 = duty_w[0];
  assign duty2 = duty_w[1];

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: reset, ramp timing, jump, retarget, tick masking, freeze, loop.
// Inputs driven and outputs sampled on the falling edge.
// Expected values are hand-derived cycle counts relative to the command acceptance edge.
module tb_pwm_fade_ctrl;
  localparam int PW = 4;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          tick_en;
  logic [PW-1:0] duty1, duty2;
  logic [1:0]    busy, done;

  int n_checks = 0;
  int n_errors = 0;

  pwm_fade_ctrl_if #(.PWM_WIDTH(PW), .RATE_WIDTH(RW)) cmd_if ();

  pwm_fade_ctrl #(.PWM_WIDTH(PW), .RATE_WIDTH(RW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tick_en (tick_en),
    .cmd     (cmd_if),
    .duty1   (duty1),
    .duty2   (duty2),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_cmd(input logic ch, input int tgt, input int rate, input logic lp);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_chan   = ch;
    cmd_if.cmd_target = PW'(tgt);
    cmd_if.cmd_rate   = RW'(rate);
    cmd_if.cmd_loop   = lp;
  endtask

  // Returns on the falling edge right after the acceptance edge.
  task automatic send(input logic ch, input int tgt, input int rate, input logic lp);
    drive_cmd(ch, tgt, rate, lp);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
  endtask

  initial begin
    int d0_cnt, d1_cnt, d0_j, d1_j, rt_j, max1, wait_j;
    bit retgt;
    int exp_d2 [12];

    reset_n = 1'b0;
    tick_en = 1'b0;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_chan   = 1'b0;
    cmd_if.cmd_target = '0;
    cmd_if.cmd_rate   = '0;
    cmd_if.cmd_loop   = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_duty1", duty1, 0);
    check("rst_duty2", duty2, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", cmd_if.cmd_ready, 0);
    reset_n = 1'b1;
    #1 check("ready_before_edge", cmd_if.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_edge", cmd_if.cmd_ready, 1);

    // Ramp 0 -> 10 at 3 ticks per step
    tick_en = 1'b1;
    send(1'b0, 10, 3, 1'b0);
    for (int j = 1; j <= 31; j++) begin
      @(negedge clk);
      check("t2_duty1", duty1, (j - 1) / 3);
      check("t2_busy0", busy[0], 1);
    end
    @(negedge clk);
    check("t2_done", done, 2'b01);
    check("t2_busy_end", busy[0], 0);
    check("t2_duty_end", duty1, 10);
    @(negedge clk);
    check("t2_done_clear", done, 0);

    // Jump with rate 0, then repeat same target
    send(1'b1, 7, 0, 1'b0);
    check("t3_not_yet", duty2, 0);
    check("t3_busy_pend", busy[1], 0);
    @(negedge clk);
    check("t3_duty2", duty2, 7);
    check("t3_done", done, 2'b10);
    check("t3_busy", busy[1], 0);
    @(negedge clk);
    check("t3_done_clear", done, 0);
    send(1'b1, 7, 5, 1'b0);
    @(negedge clk);
    check("t3_same_done", done, 2'b10);
    check("t3_same_duty", duty2, 7);
    check("t3_same_busy", busy[1], 0);
    @(negedge clk);
    check("t3_same_clear", done, 0);

    // Retarget ch1 mid-ramp while ch2 ramps down concurrently
    send(1'b0, 0, 0, 1'b0);
    @(negedge clk);
    check("t4_ch1_zero", duty1, 0);
    send(1'b1, 0, 3, 1'b0);
    send(1'b0, 15, 2, 1'b0);
    d0_cnt = 0; d1_cnt = 0; d0_j = 0; d1_j = 0; rt_j = 0; max1 = 0; retgt = 1'b0;
    for (int j = 2; j <= 40; j++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      if (done[0]) begin d0_cnt++; d0_j = j; end
      if (done[1]) begin d1_cnt++; d1_j = j; end
      if (int'(duty1) > max1) max1 = int'(duty1);
      if (j == 16) check("t4_ch2_mid", duty2, 2);
      if (j == 26) check("t4_ch1_down", duty1, 7);
      if (!retgt && duty1 == 4'd9) begin
        retgt = 1'b1;
        rt_j  = j;
        drive_cmd(1'b0, 4, 2, 1'b0);
      end
    end
    check("t4_retgt_at", rt_j, 20);
    check("t4_max1", max1, 9);
    check("t4_d0_cnt", d0_cnt, 1);
    check("t4_d0_when", d0_j, 33);
    check("t4_d1_cnt", d1_cnt, 1);
    check("t4_d1_when", d1_j, 23);
    check("t4_duty1", duty1, 4);
    check("t4_duty2", duty2, 0);
    check("t4_busy", busy, 0);

    // Command and tick in the same cycle: that tick must not step the ramp
    send(1'b0, 6, 3, 1'b0);
    for (int j = 1; j <= 13; j++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      if (j == 4)  check("t5_first_step", duty1, 5);
      if (j == 6)  drive_cmd(1'b0, 6, 3, 1'b0);
      if (j == 7)  check("t5_tick_masked", duty1, 5);
      if (j == 10) check("t5_restart", duty1, 5);
      if (j == 11) check("t5_step", duty1, 6);
      if (j == 12) check("t5_done", done, 2'b01);
      if (j == 13) check("t5_idle", busy, 0);
    end

    // tick_en low: ramp frozen
    tick_en = 1'b0;
    send(1'b0, 0, 1, 1'b0);
    repeat (50) @(negedge clk);
    check("t5_frozen_duty", duty1, 6);
    check("t5_frozen_busy", busy[0], 1);
    tick_en = 1'b1;
    wait_j = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done[0] && wait_j == 0) wait_j = k;
    end
    check("t5_resume_done_at", wait_j, 7);
    check("t5_resume_duty", duty1, 0);

`ifdef FADE_BREATHE_EN
    // Breathe: 0..3..0..3 with done at each endpoint, then stop at 0
    exp_d2 = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 2, 3};
    send(1'b1, 3, 1, 1'b1);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check("t6_duty2", duty2, exp_d2[j-1]);
      check("t6_done", done[1], (j == 5 || j == 9) ? 1 : 0);
      check("t6_busy", busy[1], 1);
    end
    drive_cmd(1'b1, 0, 1, 1'b0);
    for (int k = 13; k <= 20; k++) begin
      @(negedge clk);
      cmd_if.cmd_valid = 1'b0;
      check("t6_stop_done", done[1], (k == 18) ? 1 : 0);
      if (k == 17) check("t6_stop_duty", duty2, 0);
    end
    check("t6_stop_busy", busy[1], 0);
    check("t6_final_duty", duty2, 0);
`else
    // Loop request ignored: one-shot fade
    send(1'b1, 2, 1, 1'b1);
    d1_cnt = 0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      if (done[1]) d1_cnt++;
      if (j == 4) check("t6_done_at", done[1], 1);
    end
    check("t6_oneshot_cnt", d1_cnt, 1);
    check("t6_oneshot_duty", duty2, 2);
    check("t6_oneshot_busy", busy[1], 0);
`endif

    // Asynchronous reset mid-ramp
    send(1'b0, 8, 1, 1'b0);
    wait_j = 0;
    for (int k = 1; k <= 20 && wait_j == 0; k++) begin
      @(negedge clk);
      if (duty1 == 4'd5) wait_j = k;
    end
    check("t1_reached5", wait_j, 6);
    check("t1_busy_pre", busy[0], 1);
    reset_n = 1'b0;
    #1;
    check("t1_duty1", duty1, 0);
    check("t1_duty2", duty2, 0);
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("t1_ready_release", cmd_if.cmd_ready, 0);
    @(negedge clk);
    check("t1_ready_up", cmd_if.cmd_ready, 1);
    check("t1_duty_hold", duty1, 0);
    check("t1_busy_hold", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
